// File: rtl/mlane_pkg.sv
// mlane_pkg: lane word and beat types plus popcount/lane_mask helpers for mlane_rx_packer.
package mlane_pkg;
    localparam int P_LANES = 4;
    localparam int P_DW    = 128;
    localparam int P_KW    = 4;
    localparam int P_DEPTH = 4;
    localparam int CW      = $clog2(P_LANES) + 1;

    typedef struct packed {
        logic [P_DW-1:0] data;
        logic [P_KW-1:0] k;
    } lane_word_t;

    typedef struct packed {
        lane_word_t [P_LANES-1:0] lanes;
        logic [P_LANES-1:0]       mask;
    } beat_t;

    function automatic logic [CW-1:0] popcount(input logic [P_LANES-1:0] v);
        popcount = '0;
        for (int i = 0; i < P_LANES; i++) popcount = popcount + CW'(v[i]);
    endfunction

    function automatic logic [P_LANES-1:0] lane_mask(input logic [CW-1:0] n);
        lane_mask = '0;
        for (int i = 0; i < P_LANES; i++) lane_mask[i] = CW'(i) < n;
    endfunction
endpackage

// File: rtl/mlane_fifo.sv
// mlane_fifo: DEPTH-entry beat FIFO; head read from registered storage, zero when empty.
module mlane_fifo import mlane_pkg::*; #(
    parameter int DEPTH = P_DEPTH
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  beat_t din_i,
    input  logic  pop_i,
    output beat_t dout_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int AW = $clog2(DEPTH);
    beat_t mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic do_pop, do_push;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/mlane_rx_packer.sv
// mlane_rx_packer: compacts sparse lane words into full beats behind a FIFO, with flush of partial beats.
// Define MLANE_DROP_CNT_EN to add the saturating drop_cnt output.
module mlane_rx_packer import mlane_pkg::*; #(
    parameter int LANES = P_LANES,
    parameter int DW    = P_DW,
    parameter int KW    = P_KW,
    parameter int DEPTH = P_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*DW-1:0] rdat,
    input  logic [LANES*KW-1:0] rdatk,
    input  logic [LANES-1:0]    rdatv,
    output logic                rrdy,
    input  logic                flush,
    output logic [LANES*DW-1:0] tdat,
    output logic [LANES*KW-1:0] tdatk,
    output logic [LANES-1:0]    tdatv,
    output logic                tval,
    input  logic                tready,
    output logic                ovf
`ifdef MLANE_DROP_CNT_EN
    ,output logic [15:0]        drop_cnt
`endif
);
    localparam logic [CW-1:0] FULL_N = CW'(LANES);
    lane_word_t [LANES-1:0]   acc_q, acc_d;
    lane_word_t [2*LANES-1:0] comb;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d, total;
    logic flush_pend_q, flush_pend_d, ovf_q, fifo_full, fifo_empty, push, drop;
    beat_t push_beat, head;

    assign rrdy = !fifo_full && !flush_pend_q;
    assign drop = !rrdy && |rdatv;
    assign ovf  = ovf_q;

    // Residue sits in slots 0..acc_cnt-1; accepted words append behind it in lane order.
    always_comb begin
        comb = '0;
        for (int i = 0; i < LANES; i++) if (CW'(i) < acc_cnt_q) comb[i] = acc_q[i];
        total = acc_cnt_q;
        for (int i = 0; i < LANES; i++) begin
            if (rrdy && rdatv[i]) begin
                comb[total] = '{data: rdat[i*DW +: DW], k: rdatk[i*KW +: KW]};
                total = total + CW'(1);
            end
        end
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        push         = 1'b0;
        push_beat    = '{lanes: comb[LANES-1:0], mask: '1};
        if (flush_pend_q) begin
            if (!fifo_full) begin
                push           = acc_cnt_q != '0;
                push_beat.mask = lane_mask(acc_cnt_q);
                acc_cnt_d      = '0;
                flush_pend_d   = 1'b0;
            end
        end else if (!rrdy) begin
            flush_pend_d = flush;
        end else if (total >= FULL_N) begin
            push         = 1'b1;
            acc_d        = comb[2*LANES-1:LANES];
            acc_cnt_d    = total - FULL_N;
            flush_pend_d = flush && (total != FULL_N);
        end else begin
            push           = flush && (total != '0);
            push_beat.mask = lane_mask(total);
            acc_d          = comb[LANES-1:0];
            acc_cnt_d      = push ? '0 : total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            ovf_q        <= ovf_q | drop;
        end
    end

`ifdef MLANE_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_cnt_q} + 17'(popcount(rdatv));
    assign drop_cnt = drop_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else if (drop) drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

    mlane_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_beat),
        .pop_i   (tready),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tval  = !fifo_empty;
    assign tdatv = head.mask;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign tdat[i*DW +: DW]  = head.lanes[i].data;
        assign tdatk[i*KW +: KW] = head.lanes[i].k;
    end
endmodule

// File: tb/tb_mlane_rx_packer.sv
// tb_mlane_rx_packer: directed bench with a queue-based reference model checked every cycle.
module tb_mlane_rx_packer;
    localparam int LANES = 4, DW = 128, KW = 4, DEPTH = 4, BW = LANES*DW;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, tready = 1'b1;
    logic [BW-1:0] rdat = '0, tdat;
    logic [LANES*KW-1:0] rdatk = '0, tdatk;
    logic [LANES-1:0] rdatv = '0, tdatv;
    logic rrdy, tval, ovf;
`ifdef MLANE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    mlane_rx_packer dut (
        .clk(clk), .rst(rst), .rdat(rdat), .rdatk(rdatk), .rdatv(rdatv), .rrdy(rrdy),
        .flush(flush), .tdat(tdat), .tdatk(tdatk), .tdatv(tdatv), .tval(tval),
        .tready(tready), .ovf(ovf)
`ifdef MLANE_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; } word_s;
    typedef struct { logic [BW-1:0] d; logic [LANES*KW-1:0] k; logic [LANES-1:0] m; } beat_s;
    word_s acc[$];
    beat_s fq[$];
    bit pend, m_ovf;
    int m_drop, pass_n, tot_n;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic emit(input int n);
        beat_s b;
        b = '{d: '0, k: '0, m: '0};
        for (int i = 0; i < n; i++) begin
            b.d[i*DW +: DW] = acc[0].d;
            b.k[i*KW +: KW] = acc[0].k;
            b.m[i] = 1'b1;
            acc.delete(0);
        end
        fq.push_back(b);
    endtask

    task automatic model_step();
        bit rr, room;
        room = fq.size() < DEPTH;
        rr = room && !pend;
        if (fq.size() > 0 && tready) fq.delete(0);
        if (rdatv != 0 && !rr) begin
            m_ovf = 1'b1;
            m_drop = m_drop + $countones(rdatv);
            if (m_drop > 65535) m_drop = 65535;
        end
        if (pend) begin
            if (room) begin
                if (acc.size() > 0) emit(acc.size());
                pend = 1'b0;
            end
        end else if (!rr) begin
            pend = flush;
        end else begin
            for (int i = 0; i < LANES; i++)
                if (rdatv[i]) acc.push_back('{d: rdat[i*DW +: DW], k: rdatk[i*KW +: KW]});
            if (acc.size() >= LANES) begin
                emit(LANES);
                pend = flush && acc.size() > 0;
            end else if (flush && acc.size() > 0) emit(acc.size());
        end
    endtask

    task automatic cmp();
        beat_s f;
        f = '{d: '0, k: '0, m: '0};
        if (fq.size() > 0) f = fq[0];
        chk("tval", BW'(tval), BW'(fq.size() > 0));
        chk("tdat", tdat, f.d);
        chk("tdatk", BW'(tdatk), BW'(f.k));
        chk("tdatv", BW'(tdatv), BW'(f.m));
        chk("rrdy", BW'(rrdy), BW'(fq.size() < DEPTH && !pend));
        chk("ovf", BW'(ovf), BW'(m_ovf));
`ifdef MLANE_DROP_CNT_EN
        chk("drop_cnt", BW'(drop_cnt), BW'(m_drop));
`endif
    endtask

    task automatic cyc(input logic [LANES-1:0] v, input int a, b, c, e, input bit fl = 0, input bit tr = 1);
        int w[4];
        w = '{a, b, c, e};
        rdatv = v;
        flush = fl;
        tready = tr;
        for (int i = 0; i < LANES; i++) begin
            rdat[i*DW +: DW] = DW'(w[i]);
            rdatk[i*KW +: KW] = KW'(w[i]);
        end
        cmp();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdatv = '0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc.delete();
        fq.delete();
        pend = 1'b0;
        m_ovf = 1'b0;
        m_drop = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_tval", BW'(tval), BW'(0));
        chk("rst_rrdy", BW'(rrdy), BW'(1));
        chk("rst_ovf", BW'(ovf), BW'(0));
        chk("rst_tdat", tdat, '0);
        // dense
        cyc(4'hF, 1, 2, 3, 4);
        chk("dense_tval", BW'(tval), BW'(1));
        chk("dense_tdat", tdat, {128'h4, 128'h3, 128'h2, 128'h1});
        chk("dense_tdatv", BW'(tdatv), BW'(4'hF));
        cyc(4'h0, 0, 0, 0, 0);
        // sparse, invalid lanes carry junk
        cyc(4'b0101, 'hA, 'hEE, 'hB, 'hEE);
        cyc(4'b1010, 'hEE, 'hC, 'hEE, 'hD);
        chk("sparse_tdat", tdat, {128'hD, 128'hC, 128'hB, 128'hA});
        chk("sparse_tdatk", BW'(tdatk), BW'(16'hDCBA));
        cyc(4'h0, 0, 0, 0, 0);
        // partial flush
        cyc(4'b0111, 5, 6, 7, 'hEE);
        cyc(4'h0, 0, 0, 0, 0, 1);
        chk("pflush_tdatv", BW'(tdatv), BW'(4'b0111));
        chk("pflush_tdat", tdat, {128'h0, 128'h7, 128'h6, 128'h5});
        cyc(4'h0, 0, 0, 0, 0);
        // flush overflowing a beat, residue 3
        cyc(4'b0111, 1, 2, 3, 'hEE);
        cyc(4'hF, 'h11, 'h12, 'h13, 'h14, 1);
        chk("fovf_rrdy", BW'(rrdy), BW'(0));
        chk("fovf_full", tdat, {128'h11, 128'h3, 128'h2, 128'h1});
        cyc(4'h0, 0, 0, 0, 0);
        chk("fovf_tdatv3", BW'(tdatv), BW'(4'b0111));
        chk("fovf_part3", tdat, {128'h0, 128'h14, 128'h13, 128'h12});
        chk("fovf_rrdy1", BW'(rrdy), BW'(1));
        cyc(4'h0, 0, 0, 0, 0);
        // flush overflowing a beat, residue 2
        cyc(4'b0011, 1, 2, 'hEE, 'hEE);
        cyc(4'hF, 'h21, 'h22, 'h23, 'h24, 1);
        cyc(4'h0, 0, 0, 0, 0);
        chk("fovf_tdatv2", BW'(tdatv), BW'(4'b0011));
        chk("fovf_part2", tdat, {128'h0, 128'h0, 128'h24, 128'h23});
        cyc(4'h0, 0, 0, 0, 0);
        // backpressure, drop, flush latched while full
        cyc(4'b0001, 'h30, 'hEE, 'hEE, 'hEE, 0, 0);
        for (int j = 0; j < 4; j++) cyc(4'hF, 'h40 + 4*j, 'h41 + 4*j, 'h42 + 4*j, 'h43 + 4*j, 0, 0);
        chk("bp_rrdy", BW'(rrdy), BW'(0));
        chk("bp_head", tdat, {128'h42, 128'h41, 128'h40, 128'h30});
        cyc(4'hF, 'h50, 'h51, 'h52, 'h53, 0, 0);
        chk("bp_ovf", BW'(ovf), BW'(1));
`ifdef MLANE_DROP_CNT_EN
        chk("bp_drop_cnt", BW'(drop_cnt), BW'(4));
`endif
        cyc(4'h0, 0, 0, 0, 0, 1, 0);
        cyc(4'h0, 0, 0, 0, 0, 0, 1);
        chk("bp_hold_rrdy", BW'(rrdy), BW'(0));
        for (int j = 0; j < 6; j++) cyc(4'h0, 0, 0, 0, 0);
        chk("bp_drained", BW'(tval), BW'(0));
        chk("bp_ovf_sticky", BW'(ovf), BW'(1));
        // reset mid-operation
        cyc(4'hF, 1, 2, 3, 4, 0, 0);
        cyc(4'hF, 5, 6, 7, 8, 0, 0);
        cyc(4'b0011, 9, 10, 'hEE, 'hEE, 0, 0);
        chk("pre_rst_tval", BW'(tval), BW'(1));
        do_reset();
        chk("mrst_tval", BW'(tval), BW'(0));
        chk("mrst_rrdy", BW'(rrdy), BW'(1));
        chk("mrst_ovf", BW'(ovf), BW'(0));
        chk("mrst_tdatv", BW'(tdatv), BW'(0));
        cyc(4'h0, 0, 0, 0, 0, 1);
        cyc(4'h0, 0, 0, 0, 0);
        chk("mrst_flush_empty", BW'(tval), BW'(0));
        cyc(4'h0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
